br_resolve_unit: RTL and testbench

//   Pipelined branch/jump resolution stage for the RV64 core.
//   - Compares operands, decodes the branch condition, and computes the jump target.
//   - Detects mispredictions and provides the redirect PC.
//   - Sits between the execute-issue logic and the fetch redirect path.
//   - One registered output stage, valid/ready handshake on both sides, flush support.
//   - Saturating branch and mispredict statistics counters.

---
 rtl/br_resolve_unit_pkg.sv | 56 +++++
 rtl/br_resolve_unit_if.sv | 56 +++++
 rtl/br_resolve_unit_cmp.sv | 24 ++
 rtl/br_resolve_unit.sv | 181 ++++++++++++++++++
 tb/tb_br_resolve_unit.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/br_resolve_unit_pkg.sv
// ---------------------------------------------------------------------------
// br_pkg
//   Shared definitions for the branch resolution unit:
//   - funct3 encodings of the RV conditional branches
//   - br_req_t : request bundle captured from the issue side
//   - br_res_t : resolved result bundle held in the output stage
//   - target alignment helper shared by the datapath
//   The bundles are sized for BR_XLEN.
//   The top level must therefore be built with XLEN = BR_XLEN.
// ---------------------------------------------------------------------------
package br_pkg;

    localparam int BR_XLEN = 64;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_RSV2 = 3'b010;
    localparam logic [2:0] F3_RSV3 = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [2:0]         funct3;
        logic               is_jal;
        logic               is_jalr;
        logic [BR_XLEN-1:0] pc;
        logic [BR_XLEN-1:0] rs1;
        logic [BR_XLEN-1:0] rs2;
        logic [BR_XLEN-1:0] imm;
        logic               pred_taken;
        logic [BR_XLEN-1:0] pred_target;
    } br_req_t;

    typedef struct packed {
        logic               taken;
        logic [BR_XLEN-1:0] target;
        logic [BR_XLEN-1:0] redirect_pc;
        logic               mispredict;
        logic               misalign;
        logic               illegal;
    } br_res_t;

    // With compressed instructions only bit 0 must be clear; otherwise both low bits.
    function automatic logic target_misaligned(input logic [1:0] low_bits, input logic rvc);
        logic result;
        if (rvc) begin
            result = low_bits[0];
        end else begin
            result = low_bits[1] | low_bits[0];
        end
        return result;
    endfunction

endpackage

// File: rtl/br_resolve_unit_if.sv
// ---------------------------------------------------------------------------
// br_resolve_unit_if
//   Request/result handshake bundle of the branch resolution unit.
//   slave  : the resolution unit (consumes requests, produces results/stats)
//   master : the surrounding pipeline (issue side + fetch redirect consumer)
//   Signals:
//     flush                       kill held result, block input this cycle
//     in_valid / in_ready         request handshake
//     in_funct3 .. in_pred_target request payload
//     out_valid / out_ready       result handshake
//     out_taken .. out_illegal    result payload
//     stat_br_cnt / stat_misp_cnt saturating retire statistics
// ---------------------------------------------------------------------------
interface br_resolve_unit_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) ();

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic             in_is_jal;
    logic             in_is_jalr;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [XLEN-1:0]  in_imm;
    logic             in_pred_taken;
    logic [XLEN-1:0]  in_pred_target;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic [XLEN-1:0]  out_target;
    logic [XLEN-1:0]  out_redirect_pc;
    logic             out_mispredict;
    logic             out_misalign;
    logic             out_illegal;
    logic [CNT_W-1:0] stat_br_cnt;
    logic [CNT_W-1:0] stat_misp_cnt;

    modport slave (
        input  flush, in_valid, in_funct3, in_is_jal, in_is_jalr, in_pc,
               in_rs1, in_rs2, in_imm, in_pred_taken, in_pred_target, out_ready,
        output in_ready, out_valid, out_taken, out_target, out_redirect_pc,
               out_mispredict, out_misalign, out_illegal, stat_br_cnt, stat_misp_cnt
    );

    modport master (
        output flush, in_valid, in_funct3, in_is_jal, in_is_jalr, in_pc,
               in_rs1, in_rs2, in_imm, in_pred_taken, in_pred_target, out_ready,
        input  in_ready, out_valid, out_taken, out_target, out_redirect_pc,
               out_mispredict, out_misalign, out_illegal, stat_br_cnt, stat_misp_cnt
    );

endinterface

// File: rtl/br_resolve_unit_cmp.sv
// ---------------------------------------------------------------------------
// br_cmp
//   Combinational operand comparator for branch resolution.
//   Ports:
//     i_a, i_b  operands (XLEN bits)
//     o_eq      i_a == i_b
//     o_lt      i_a <  i_b, two's-complement signed
//     o_ltu     i_a <  i_b, unsigned
// ---------------------------------------------------------------------------
module br_cmp #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_eq,
    output logic            o_lt,
    output logic            o_ltu
);

    assign o_eq  = (i_a == i_b);
    assign o_lt  = ($signed(i_a) < $signed(i_b));
    assign o_ltu = (i_a < i_b);

endmodule

// File: rtl/br_resolve_unit.sv
// ---------------------------------------------------------------------------
// br_resolve_unit
//   Branch/jump resolution stage between execute issue and fetch redirect.
//   Resolves the branch condition, computes the target, flags mispredicts,
//   misaligned targets and reserved funct3 values, and holds the result in a
//   single output register with valid/ready handshakes on both sides.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    br_resolve_unit_if.slave (request, result, flush, statistics)
//   Parameters:
//     XLEN   operand / PC width (must equal br_pkg::BR_XLEN)
//     RVC    1: targets need 2-byte alignment, 0: 4-byte alignment
//     CNT_W  width of each saturating statistics counter
// ---------------------------------------------------------------------------
module br_resolve_unit
    import br_pkg::*;
#(
    parameter int XLEN  = BR_XLEN,
    parameter bit RVC   = 1'b0,
    parameter int CNT_W = 32
) (
    input logic             clk,
    input logic             rst_n,
    br_resolve_unit_if.slave bus
);

    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(3'd4);
    localparam logic [XLEN-1:0] JALR_MASK = ~XLEN'(1'b1);

    br_req_t          w_req;
    br_res_t          w_res;
    br_res_t          r_res;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_misp_cnt;

    logic             w_eq;
    logic             w_lt;
    logic             w_ltu;
    logic [XLEN-1:0]  w_pc_imm;
    logic [XLEN-1:0]  w_rs1_imm;
    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_target;
    logic             w_taken;
    logic             w_illegal;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_handoff;

    // Saturating increment: an all-ones counter stays at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (&value) begin
            result = value;
        end else begin
            result = value + CNT_W'(1'b1);
        end
        return result;
    endfunction

    // Gather the request payload into one bundle.
    always_comb begin
        w_req             = '0;
        w_req.funct3      = bus.in_funct3;
        w_req.is_jal      = bus.in_is_jal;
        w_req.is_jalr     = bus.in_is_jalr;
        w_req.pc          = bus.in_pc;
        w_req.rs1         = bus.in_rs1;
        w_req.rs2         = bus.in_rs2;
        w_req.imm         = bus.in_imm;
        w_req.pred_taken  = bus.in_pred_taken;
        w_req.pred_target = bus.in_pred_target;
    end

    br_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .i_a   (w_req.rs1),
        .i_b   (w_req.rs2),
        .o_eq  (w_eq),
        .o_lt  (w_lt),
        .o_ltu (w_ltu)
    );

    // All adders wrap modulo 2^XLEN; JALR clears bit 0 of its sum.
    assign w_pc_imm   = w_req.pc + w_req.imm;
    assign w_rs1_imm  = w_req.rs1 + w_req.imm;
    assign w_pc_plus4 = w_req.pc + PC_STEP;

    // Condition decode with priority jalr > jal > funct3.
    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        w_target  = w_pc_imm;
        if (w_req.is_jalr) begin
            w_taken  = 1'b1;
            w_target = w_rs1_imm & JALR_MASK;
        end else if (w_req.is_jal) begin
            w_taken  = 1'b1;
        end else begin
            case (w_req.funct3)
                F3_BEQ:  w_taken = w_eq;
                F3_BNE:  w_taken = ~w_eq;
                F3_BLT:  w_taken = w_lt;
                F3_BGE:  w_taken = ~w_lt;
                F3_BLTU: w_taken = w_ltu;
                F3_BGEU: w_taken = ~w_ltu;
                F3_RSV2: w_illegal = 1'b1;
                F3_RSV3: w_illegal = 1'b1;
                default: w_illegal = 1'b1;
            endcase
        end
    end

    // Result bundle: redirect, mispredict and alignment derived from the decode.
    always_comb begin
        w_res             = '0;
        w_res.taken       = w_taken;
        w_res.target      = w_target;
        w_res.illegal     = w_illegal;
        w_res.misalign    = w_taken & target_misaligned(w_target[1:0], RVC);
        if (w_taken) begin
            w_res.redirect_pc = w_target;
        end else begin
            w_res.redirect_pc = w_pc_plus4;
        end
        w_res.mispredict  = (w_req.pred_taken != w_taken) ||
                            (w_taken && (w_req.pred_target != w_target));
    end

    // Flush blocks input for the cycle; otherwise the stage accepts when empty or draining.
    assign w_in_ready = ~bus.flush & (~r_out_valid | bus.out_ready);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_handoff  = r_out_valid & bus.out_ready;

    // Output stage: load on acceptance, drop on handoff or flush, payload held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_res       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_res       <= w_res;
        end else if (w_handoff || bus.flush) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Retire statistics: a handoff in a flush cycle still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_cnt   <= '0;
            r_misp_cnt <= '0;
        end else if (w_handoff) begin
            r_br_cnt <= sat_inc(r_br_cnt);
            if (r_res.mispredict) begin
                r_misp_cnt <= sat_inc(r_misp_cnt);
            end else begin
                r_misp_cnt <= r_misp_cnt;
            end
        end else begin
            r_br_cnt   <= r_br_cnt;
            r_misp_cnt <= r_misp_cnt;
        end
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.out_valid       = r_out_valid;
    assign bus.out_taken       = r_res.taken;
    assign bus.out_target      = r_res.target;
    assign bus.out_redirect_pc = r_res.redirect_pc;
    assign bus.out_mispredict  = r_res.mispredict;
    assign bus.out_misalign    = r_res.misalign;
    assign bus.out_illegal     = r_res.illegal;
    assign bus.stat_br_cnt     = r_br_cnt;
    assign bus.stat_misp_cnt   = r_misp_cnt;

endmodule

// File: tb/tb_br_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_br_resolve_unit
//   Two instances share one stimulus stream:
//     dut_a : RVC = 0, CNT_W = 32
//     dut_b : RVC = 1, CNT_W = 4  (alignment variant and counter saturation)
//   Hand-computed vector table, directed back-pressure / flush / saturation /
//   async-reset sequences, then randomized traffic against a reference model.
// ---------------------------------------------------------------------------
module tb_br_resolve_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    br_resolve_unit_if #(.XLEN(64), .CNT_W(32)) bif_a ();
    br_resolve_unit_if #(.XLEN(64), .CNT_W(4))  bif_b ();

    assign bif_b.flush          = bif_a.flush;
    assign bif_b.in_valid       = bif_a.in_valid;
    assign bif_b.in_funct3      = bif_a.in_funct3;
    assign bif_b.in_is_jal      = bif_a.in_is_jal;
    assign bif_b.in_is_jalr     = bif_a.in_is_jalr;
    assign bif_b.in_pc          = bif_a.in_pc;
    assign bif_b.in_rs1         = bif_a.in_rs1;
    assign bif_b.in_rs2         = bif_a.in_rs2;
    assign bif_b.in_imm         = bif_a.in_imm;
    assign bif_b.in_pred_taken  = bif_a.in_pred_taken;
    assign bif_b.in_pred_target = bif_a.in_pred_target;
    assign bif_b.out_ready      = bif_a.out_ready;

    br_resolve_unit #(.XLEN(64), .RVC(1'b0), .CNT_W(32)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (bif_a.slave)
    );
    br_resolve_unit #(.XLEN(64), .RVC(1'b1), .CNT_W(4)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (bif_b.slave)
    );

    typedef struct packed {
        logic        taken;
        logic [63:0] target;
        logic [63:0] redir;
        logic        misp;
        logic        mal_a;
        logic        mal_b;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic        jal;
        logic        jalr;
        logic [63:0] pc;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] imm;
        logic        pt;
        logic [63:0] ptgt;
        exp_t        e;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit              m_valid;
    exp_t            m_res;
    longint unsigned m_br_a, m_misp_a, m_br_b, m_misp_b;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behaviour from the architectural rules: plain integer compares and adds.
    function automatic exp_t ref_resolve(input logic [2:0] f3, input logic jal, input logic jalr,
                                         input logic [63:0] pc, input logic [63:0] rs1,
                                         input logic [63:0] rs2, input logic [63:0] imm,
                                         input logic pt, input logic [63:0] ptgt);
        exp_t   r;
        longint sa = longint'(rs1);
        longint sb = longint'(rs2);
        r = '0;
        r.target = jalr ? ((rs1 + imm) & ~64'd1) : (pc + imm);
        if (jalr || jal) r.taken = 1'b1;
        else begin
            case (f3)
                3'd0: r.taken = (rs1 == rs2);
                3'd1: r.taken = (rs1 != rs2);
                3'd4: r.taken = (sa < sb);
                3'd5: r.taken = (sa >= sb);
                3'd6: r.taken = (rs1 < rs2);
                3'd7: r.taken = (rs1 >= rs2);
                default: r.ill = 1'b1;
            endcase
        end
        r.redir = r.taken ? r.target : pc + 64'd4;
        r.mal_a = r.taken && (r.target % 64'd4 != 64'd0);
        r.mal_b = r.taken && (r.target % 64'd2 != 64'd0);
        r.misp  = (pt != r.taken) || (r.taken && ptgt != r.target);
        return r;
    endfunction

    function automatic vec_t mk(input logic [2:0] f3, input logic jal, input logic jalr,
                                input logic [63:0] pc, input logic [63:0] rs1, input logic [63:0] rs2,
                                input logic [63:0] imm, input logic pt, input logic [63:0] ptgt,
                                input logic tk, input logic [63:0] tgt, input logic [63:0] rd,
                                input logic mp, input logic ma, input logic mb, input logic il);
        vec_t v;
        v.f3 = f3; v.jal = jal; v.jalr = jalr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.pt = pt; v.ptgt = ptgt;
        v.e.taken = tk; v.e.target = tgt; v.e.redir = rd; v.e.misp = mp;
        v.e.mal_a = ma; v.e.mal_b = mb; v.e.ill = il;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bif_a.in_funct3      = v.f3;
        bif_a.in_is_jal      = v.jal;
        bif_a.in_is_jalr     = v.jalr;
        bif_a.in_pc          = v.pc;
        bif_a.in_rs1         = v.rs1;
        bif_a.in_rs2         = v.rs2;
        bif_a.in_imm         = v.imm;
        bif_a.in_pred_taken  = v.pt;
        bif_a.in_pred_target = v.ptgt;
    endtask

    task automatic model_clear();
        m_valid = 1'b0; m_res = '0;
        m_br_a = 0; m_misp_a = 0; m_br_b = 0; m_misp_b = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid_a"}, 64'(bif_a.out_valid), 64'(m_valid));
        chk({tag, ".valid_b"}, 64'(bif_b.out_valid), 64'(m_valid));
        if (m_valid) begin
            chk({tag, ".taken"},  64'(bif_a.out_taken), 64'(m_res.taken));
            chk({tag, ".target"}, bif_a.out_target, m_res.target);
            chk({tag, ".redir"},  bif_a.out_redirect_pc, m_res.redir);
            chk({tag, ".misp"},   64'(bif_a.out_mispredict), 64'(m_res.misp));
            chk({tag, ".ill"},    64'(bif_a.out_illegal), 64'(m_res.ill));
            chk({tag, ".mal_a"},  64'(bif_a.out_misalign), 64'(m_res.mal_a));
            chk({tag, ".mal_b"},  64'(bif_b.out_misalign), 64'(m_res.mal_b));
            chk({tag, ".tgt_b"},  bif_b.out_target, m_res.target);
        end
        chk({tag, ".br_a"},   64'(bif_a.stat_br_cnt), m_br_a);
        chk({tag, ".misp_a"}, 64'(bif_a.stat_misp_cnt), m_misp_a);
        chk({tag, ".br_b"},   64'(bif_b.stat_br_cnt), m_br_b);
        chk({tag, ".misp_b"}, 64'(bif_b.stat_misp_cnt), m_misp_b);
    endtask

    // One clock: inputs already driven at the preceding falling edge.
    task automatic step(input string tag);
        bit   exp_rdy, acc, hs;
        exp_t nres;
        #1;
        exp_rdy = !bif_a.flush && (!m_valid || bif_a.out_ready);
        chk({tag, ".in_ready_a"}, 64'(bif_a.in_ready), 64'(exp_rdy));
        chk({tag, ".in_ready_b"}, 64'(bif_b.in_ready), 64'(exp_rdy));
        acc  = bif_a.in_valid && exp_rdy;
        hs   = m_valid && bif_a.out_ready;
        nres = ref_resolve(bif_a.in_funct3, bif_a.in_is_jal, bif_a.in_is_jalr, bif_a.in_pc,
                           bif_a.in_rs1, bif_a.in_rs2, bif_a.in_imm,
                           bif_a.in_pred_taken, bif_a.in_pred_target);
        @(posedge clk);
        if (hs) begin
            if (m_br_a < 64'hFFFF_FFFF) m_br_a++;
            if (m_br_b < 64'd15) m_br_b++;
            if (m_res.misp) begin
                if (m_misp_a < 64'hFFFF_FFFF) m_misp_a++;
                if (m_misp_b < 64'd15) m_misp_b++;
            end
        end
        if (acc) begin
            m_valid = 1'b1;
            m_res   = nres;
        end else if (hs || bif_a.flush) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        bif_a.flush = 1'b0; bif_a.in_valid = 1'b0; bif_a.out_ready = 1'b0;
        drive(mk(3'd0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0,
                 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] held_tgt;
        longint unsigned cnt0;

        tbl[0] = mk(3'b000, 1'b0, 1'b0, 64'h1000, 64'd5, 64'd5, 64'h20, 1'b0, 64'h0,
                    1'b1, 64'h1020, 64'h1020, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(3'b100, 1'b0, 1'b0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 1'b1, 64'h1040,
                    1'b1, 64'h1040, 64'h1040, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[2] = mk(3'b110, 1'b0, 1'b0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 1'b1, 64'h1040,
                    1'b0, 64'h1040, 64'h1004, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[3] = mk(3'b000, 1'b0, 1'b1, 64'h3000, 64'h2003, 64'd0, 64'd0, 1'b1, 64'h2002,
                    1'b1, 64'h2002, 64'h2002, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[4] = mk(3'b010, 1'b0, 1'b0, 64'h100, 64'd0, 64'd0, 64'd8, 1'b0, 64'h0,
                    1'b0, 64'h108, 64'h104, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[5] = mk(3'b011, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 64'd8, 1'b1, 64'h8,
                    1'b1, 64'h4, 64'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[6] = mk(3'b001, 1'b0, 1'b0, 64'h2000, 64'd1, 64'd2, 64'h6, 1'b0, 64'h0,
                    1'b1, 64'h2006, 64'h2006, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[7] = mk(3'b101, 1'b0, 1'b0, 64'h10, 64'h8000_0000_0000_0000, 64'd0, 64'h10, 1'b0, 64'h0,
                    1'b0, 64'h20, 64'h14, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[8] = mk(3'b111, 1'b0, 1'b0, 64'h10, 64'h8000_0000_0000_0000, 64'd0, 64'h10, 1'b1, 64'h20,
                    1'b1, 64'h20, 64'h20, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[9] = mk(3'b010, 1'b1, 1'b1, 64'h50, 64'h1001, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'hFFE,
                    1'b1, 64'hFFE, 64'hFFE, 1'b0, 1'b1, 1'b0, 1'b0);

        // reset state
        do_reset();
        chk("rst.in_ready", 64'(bif_a.in_ready), 64'd1);
        chk("rst.target",   bif_a.out_target, 64'd0);
        chk("rst.redir",    bif_a.out_redirect_pc, 64'd0);
        chk("rst.flags",    64'({bif_a.out_taken, bif_a.out_mispredict, bif_a.out_misalign,
                                 bif_a.out_illegal}), 64'd0);
        check_outputs("rst");

        // hand-computed vector table at full throughput
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i]);
            bif_a.in_valid = 1'b1; bif_a.out_ready = 1'b1; bif_a.flush = 1'b0;
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.taken", i),  64'(bif_a.out_taken), 64'(tbl[i].e.taken));
            chk($sformatf("vec%0d.target", i), bif_a.out_target, tbl[i].e.target);
            chk($sformatf("vec%0d.redir", i),  bif_a.out_redirect_pc, tbl[i].e.redir);
            chk($sformatf("vec%0d.misp", i),   64'(bif_a.out_mispredict), 64'(tbl[i].e.misp));
            chk($sformatf("vec%0d.mal_a", i),  64'(bif_a.out_misalign), 64'(tbl[i].e.mal_a));
            chk($sformatf("vec%0d.mal_b", i),  64'(bif_b.out_misalign), 64'(tbl[i].e.mal_b));
            chk($sformatf("vec%0d.ill", i),    64'(bif_a.out_illegal), 64'(tbl[i].e.ill));
        end

        // back-pressure: result of vec9 must hold for 3 cycles
        cnt0 = m_br_a;
        held_tgt = tbl[9].e.target;
        drive(tbl[0]);
        bif_a.in_valid = 1'b1; bif_a.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("bp");
            chk("bp.in_ready", 64'(bif_a.in_ready), 64'd0);
            chk("bp.valid",    64'(bif_a.out_valid), 64'd1);
            chk("bp.target",   bif_a.out_target, held_tgt);
            chk("bp.br_cnt",   64'(bif_a.stat_br_cnt), cnt0);
        end
        bif_a.in_valid = 1'b0; bif_a.out_ready = 1'b1;
        step("bp_rel");
        chk("bp_rel.br_cnt", 64'(bif_a.stat_br_cnt), cnt0 + 64'd1);
        chk("bp_rel.valid",  64'(bif_a.out_valid), 64'd0);

        // flush together with a handoff and a new request
        drive(tbl[1]);
        bif_a.in_valid = 1'b1;
        step("fl_load");
        cnt0 = m_br_a;
        drive(tbl[2]);
        bif_a.flush = 1'b1;
        #1 chk("fl.in_ready", 64'(bif_a.in_ready), 64'd0);
        @(negedge clk);
        step("fl");
        chk("fl.valid",  64'(bif_a.out_valid), 64'd0);
        chk("fl.br_cnt", 64'(bif_a.stat_br_cnt), cnt0 + 64'd1);
        bif_a.flush = 1'b0; bif_a.in_valid = 1'b0;
        step("fl_after");
        chk("fl_after.br_cnt", 64'(bif_a.stat_br_cnt), cnt0 + 64'd1);

        // saturation of the 4-bit counters after 20 mispredicting handoffs
        do_reset();
        drive(tbl[0]);
        bif_a.in_valid = 1'b1; bif_a.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step("sat");
        bif_a.in_valid = 1'b0;
        step("sat_end");
        chk("sat.br_b",   64'(bif_b.stat_br_cnt), 64'hF);
        chk("sat.misp_b", 64'(bif_b.stat_misp_cnt), 64'hF);
        chk("sat.br_a",   64'(bif_a.stat_br_cnt), 64'd20);
        chk("sat.misp_a", 64'(bif_a.stat_misp_cnt), 64'd20);

        // randomized traffic with an asynchronous reset in the middle
        for (int c = 0; c < 600; c++) begin
            logic [63:0] r1;
            int          k;
            if (c == 300) begin
                bif_a.in_valid = 1'b1; bif_a.out_ready = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk("arst.valid_a", 64'(bif_a.out_valid), 64'd0);
                chk("arst.valid_b", 64'(bif_b.out_valid), 64'd0);
                chk("arst.cnt_a",   64'({bif_a.stat_br_cnt, bif_a.stat_misp_cnt}), 64'd0);
                chk("arst.cnt_b",   64'({bif_b.stat_br_cnt, bif_b.stat_misp_cnt}), 64'd0);
                chk("arst.taken",   64'(bif_a.out_taken), 64'd0);
                model_clear();
                @(negedge clk);
                rst_n = 1'b1;
            end
            r1 = {$urandom(), $urandom()};
            k  = $urandom_range(0, 9);
            bif_a.in_funct3  = 3'($urandom_range(0, 7));
            bif_a.in_is_jalr = (k == 0);
            bif_a.in_is_jal  = (k == 1);
            bif_a.in_rs1     = ($urandom_range(0, 1) == 0) ? r1 : 64'($urandom_range(0, 7));
            bif_a.in_rs2     = ($urandom_range(0, 3) == 0) ? bif_a.in_rs1 :
                               (($urandom_range(0, 1) == 0) ? {$urandom(), $urandom()}
                                                            : 64'($urandom_range(0, 7)));
            bif_a.in_imm     = 64'($urandom_range(0, 255)) - 64'd128;
            bif_a.in_pc      = {$urandom(), $urandom()} & ~64'($urandom_range(0, 3));
            bif_a.in_pred_taken  = 1'($urandom_range(0, 1));
            bif_a.in_pred_target = ($urandom_range(0, 1) == 0) ? bif_a.in_pc + bif_a.in_imm
                                                               : {$urandom(), $urandom()};
            bif_a.in_valid   = ($urandom_range(0, 3) != 0);
            bif_a.out_ready  = ($urandom_range(0, 3) != 0);
            bif_a.flush      = ($urandom_range(0, 15) == 0);
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
